// File: rtl/ysyx_24090003_lsu.sv
// ysyx_24090003_lsu: load/store and write-back stage of a multi-cycle core.
// Takes one executed instruction at a time. It performs at most one data-memory
// access (a valid/ready request followed by a response), then issues one cycle
// of register-file and PC write pulses.
// Optional build macro LSU_MISALIGN_CHECK_EN: adds misalign_err. With it,
// misaligned half/word accesses skip memory and go straight to write-back.
module ysyx_24090003_lsu #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ex_reg_wdata,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_wen,
    input  logic            ex_mem_ren,
    input  logic            ex_mem_wen,
    input  logic [2:0]      ex_funct,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_mem_wdata,
    input  logic [XLEN-1:0] ex_npc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            rf_wen,
    output logic [RD_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic            misalign_err,
`endif
    output logic            pc_wen,
    output logic [XLEN-1:0] pc_next
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

    state_t      state_reg, state_next;
    logic        reg_wen_reg;
    logic [2:0]  funct_reg;
    logic [1:0]  off_reg;
    logic        is_access;
    logic        take_misalign;

    // Byte strobes for a store: byte at offset, half at the half-word slot, else full word.
    function automatic logic [3:0] store_mask(input logic [2:0] f, input logic [1:0] o);
        case (f)
            3'b000:  store_mask = 4'b0001 << o;
            3'b001:  store_mask = 4'b0011 << {o[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the strobes alone pick the target bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f, input logic [XLEN-1:0] d);
        case (f)
            3'b000:  store_data = {4{d[7:0]}};
            3'b001:  store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Pick a lane out of the aligned word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f, input logic [1:0] o,
                                                 input logic [XLEN-1:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[{o, 3'b000} +: 8];
        h = o[1] ? r[31:16] : r[15:0];
        case (f)
            3'b000:  load_fmt = {{(XLEN-8){b[7]}}, b};
            3'b001:  load_fmt = {{(XLEN-16){h[15]}}, h};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}}, b};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, h};
            default: load_fmt = r;
        endcase
    endfunction

    assign in_ready = (state_reg == IDLE);

    // Classify the incoming instruction: memory access, and whether it is misaligned.
    always_comb begin
        is_access     = ex_mem_wen | ex_mem_ren;
        take_misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        take_misalign = is_access &&
                        (((ex_funct[1:0] == 2'b01) && ex_addr[0]) ||
                         ((ex_funct == 3'b010) && (ex_addr[1:0] != 2'b00)));
`endif
    end

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (is_access && !take_misalign) state_next = REQ;
                    else                             state_next = WB;
                end
            end
            REQ:  if (mem_req_ready)  state_next = mem_req_wen ? WB : RESP;
            RESP: if (mem_resp_valid) state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the instruction, drive the request, and build the write-back pulses.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= 4'b0000;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            pc_wen        <= 1'b0;
            pc_next       <= '0;
            reg_wen_reg   <= 1'b0;
            funct_reg     <= 3'b000;
            off_reg       <= 2'b00;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_err  <= 1'b0;
`endif
        end else begin
            // Write-back outputs are single-cycle pulses.
            rf_wen <= 1'b0;
            pc_wen <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        reg_wen_reg <= ex_reg_wen;
                        funct_reg   <= ex_funct;
                        off_reg     <= ex_addr[1:0];
                        rf_waddr    <= ex_rd;
                        rf_wdata    <= ex_reg_wdata;
                        pc_next     <= ex_npc;
                        if (take_misalign) begin
                            pc_wen <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                            misalign_err <= 1'b1;
`endif
                        end else if (is_access) begin
                            // Store wins when both ren and wen are set.
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= ex_mem_wen;
                            mem_req_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                            mem_req_wdata <= ex_mem_wen ? store_data(ex_funct, ex_mem_wdata) : '0;
                            mem_req_wmask <= ex_mem_wen ? store_mask(ex_funct, ex_addr[1:0]) : 4'b0000;
                        end else begin
                            rf_wen <= ex_reg_wen && (ex_rd != '0);
                            pc_wen <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_wen) pc_wen <= 1'b1;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        rf_wdata <= load_fmt(funct_reg, off_reg, mem_resp_rdata);
                        rf_wen   <= reg_wen_reg && (rf_waddr != '0);
                        pc_wen   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_lsu.sv
// Directed, table-driven bench for ysyx_24090003_lsu, plus hand-written
// sequences for reset-in-flight behaviour.
module tb_ysyx_24090003_lsu;

    logic        cpu_clk, cpu_rst;
    logic        in_valid, in_ready;
    logic [31:0] ex_reg_wdata, ex_addr, ex_mem_wdata, ex_npc;
    logic [4:0]  ex_rd;
    logic        ex_reg_wen, ex_mem_ren, ex_mem_wen;
    logic [2:0]  ex_funct;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_wen;
    logic [31:0] pc_next;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24090003_lsu #(.XLEN(32), .RD_W(5)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_reg_wdata(ex_reg_wdata), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
        .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_funct(ex_funct),
        .ex_addr(ex_addr), .ex_mem_wdata(ex_mem_wdata), .ex_npc(ex_npc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .pc_wen(pc_wen), .pc_next(pc_next)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        reg_wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        ren;
        logic        wen;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] mwdata;
        logic [31:0] npc;
        logic [31:0] rdata;
        int          req_dly;
        int          resp_dly;
        logic        poke;      // assert in_valid while busy waiting for the response
        logic        early;     // drive a bogus response in the handshake cycle
        logic        mis;       // expect the misaligned shortcut
        logic        e_rfwen;
        logic [31:0] e_rfwdata;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_mdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge cpu_clk);
    endtask

    // Present one instruction, play the memory side, and check the write-back cycle.
    task automatic do_txn(input int idx, input vec_t v);
        logic acc;
        acc          = v.wen | v.ren;
        in_valid     = 1'b1;
        ex_reg_wen   = v.reg_wen;
        ex_rd        = v.rd;
        ex_reg_wdata = v.wdata;
        ex_mem_ren   = v.ren;
        ex_mem_wen   = v.wen;
        ex_funct     = v.funct;
        ex_addr      = v.addr;
        ex_mem_wdata = v.mwdata;
        ex_npc       = v.npc;
        chk("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        if (v.mis) begin
            chk("mis_no_req", mem_req_valid, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
            chk("mis_err", misalign_err, 1'b1);
`endif
        end else if (acc) begin
            chk("req_valid", mem_req_valid, 1'b1);
            chk("req_wen", mem_req_wen, v.wen);
            chk("req_addr", mem_req_addr, v.e_addr);
            if (v.wen) begin
                chk("req_wmask", {28'd0, mem_req_wmask}, {28'd0, v.e_mask});
                chk("req_wdata", mem_req_wdata, v.e_mdata);
            end
            for (int i = 0; i < v.req_dly; i++) begin
                step();
                chk("req_hold_valid", mem_req_valid, 1'b1);
                chk("req_hold_addr", mem_req_addr, v.e_addr);
            end
            mem_req_ready = 1'b1;
            if (v.early) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = ~v.rdata;
            end
            step();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            chk("req_drop", mem_req_valid, 1'b0);
            if (!v.wen) begin
                chk("resp_wait_no_pc", pc_wen, 1'b0);
                for (int i = 0; i < v.resp_dly; i++) begin
                    if (v.poke) begin
                        in_valid     = 1'b1;
                        ex_rd        = 5'd9;
                        ex_reg_wen   = 1'b1;
                        ex_mem_ren   = 1'b0;
                        ex_mem_wen   = 1'b0;
                        ex_reg_wdata = 32'h0000_0BAD;
                        ex_npc       = 32'h0;
                    end
                    step();
                    if (v.poke) chk("busy_not_ready", in_ready, 1'b0);
                end
                in_valid       = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = v.rdata;
                step();
                mem_resp_valid = 1'b0;
            end
        end
        // Write-back cycle.
        chk("wb_pc_wen", pc_wen, 1'b1);
        chk("wb_pc_next", pc_next, v.npc);
        chk("wb_rf_wen", rf_wen, v.e_rfwen);
        chk("wb_in_ready", in_ready, 1'b0);
        if (v.e_rfwen) begin
            chk("wb_rf_waddr", {27'd0, rf_waddr}, {27'd0, v.rd});
            chk("wb_rf_wdata", rf_wdata, v.e_rfwdata);
        end
`ifdef LSU_MISALIGN_CHECK_EN
        if (!v.mis) chk("wb_no_mis", misalign_err, 1'b0);
`endif
        $display("[TB] txn %0d addr=%h rf_wen=%0b rf_waddr=%0d rf_wdata=%h pc_next=%h",
                 idx, v.addr, rf_wen, rf_waddr, rf_wdata, pc_next);
        step();
        chk("post_pc_wen", pc_wen, 1'b0);
        chk("post_rf_wen", rf_wen, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("post_mis", misalign_err, 1'b0);
`endif
    endtask

    initial begin
        vec_t alu;
        //            rwen rd    wdata         ren   wen   fn      addr           mwdata         npc            rdata          rq rs poke  early mis   erfw  erfwdata       eaddr          emask  emdata
        vecs[0]  = '{1'b1, 5'd5, 32'h0000_0007, 1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         32'h8000_0004, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0,         4'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 3'b000, 32'h8000_1003, 32'h0000_00AB, 32'h8000_0008, 32'h0,         3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_1000, 4'h8, 32'hABAB_ABAB};
        vecs[2]  = '{1'b1, 5'd3, 32'h0,         1'b1, 1'b0, 3'b000, 32'h8000_2002, 32'h0,         32'h8000_000C, 32'h12F4_5678, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4, 32'h8000_2000, 4'h0, 32'h0};
        vecs[3]  = '{1'b1, 5'd3, 32'h0,         1'b1, 1'b0, 3'b100, 32'h8000_2002, 32'h0,         32'h8000_0010, 32'h12F4_5678, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00F4, 32'h8000_2000, 4'h0, 32'h0};
        vecs[4]  = '{1'b1, 5'd10,32'h0,         1'b1, 1'b0, 3'b001, 32'h8000_2006, 32'h0,         32'h8000_0014, 32'h8001_FFFF, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_8001, 32'h8000_2004, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 5'd0, 32'h0,         1'b1, 1'b0, 3'b010, 32'h8000_3000, 32'h0,         32'h8000_0018, 32'hDEAD_BEEF, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_3000, 4'h0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 3'b001, 32'h8000_1002, 32'h1234_ABCD, 32'h8000_001C, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_1000, 4'hC, 32'hABCD_ABCD};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 3'b010, 32'h8000_1008, 32'h1122_3344, 32'h8000_0020, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_1008, 4'hF, 32'h1122_3344};
        vecs[8]  = '{1'b1, 5'd11,32'h0,         1'b1, 1'b0, 3'b101, 32'h8000_2000, 32'h0,         32'h8000_0024, 32'h8001_FFFF, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 32'h8000_2000, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 5'd4, 32'h0,         1'b1, 1'b1, 3'b010, 32'h8000_1010, 32'hCAFE_F00D, 32'h8000_0028, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_1010, 4'hF, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 5'd0, 32'h0000_0055, 1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         32'h8000_002C, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[11] = '{1'b1, 5'd6, 32'h0,         1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,         32'h8000_0030, 32'h0A0B_0C0D, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h8000_0000, 4'h0, 32'h0};
`else
        vecs[11] = '{1'b1, 5'd6, 32'h0,         1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,         32'h8000_0030, 32'h0A0B_0C0D, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A0B_0C0D, 32'h8000_0000, 4'h0, 32'h0};
`endif
        vecs[12] = '{1'b1, 5'd8, 32'h0,         1'b1, 1'b0, 3'b010, 32'h8000_5004, 32'h0,         32'h8000_0034, 32'h55AA_33CC, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55AA_33CC, 32'h8000_5004, 4'h0, 32'h0};

        in_valid = 0; ex_reg_wdata = 0; ex_rd = 0; ex_reg_wen = 0; ex_mem_ren = 0;
        ex_mem_wen = 0; ex_funct = 0; ex_addr = 0; ex_mem_wdata = 0; ex_npc = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;

        // Reset state.
        cpu_rst = 1'b1;
        step(); step();
        cpu_rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_req_wmask", {28'd0, mem_req_wmask}, 32'h0);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_pc_wen", pc_wen, 1'b0);
        chk("rst_pc_next", pc_next, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rst_mis", misalign_err, 1'b0);
`endif

        for (int i = 0; i < 13; i++) do_txn(i, vecs[i]);

        // Reset while waiting for a load response: abandoned, late response ignored.
        in_valid = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd7; ex_mem_ren = 1'b1; ex_mem_wen = 1'b0;
        ex_funct = 3'b010; ex_addr = 32'h8000_4000; ex_npc = 32'h8000_0040;
        step();
        in_valid = 1'b0;
        chk("rst_seq_req", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rst_seq_in_resp", in_ready, 1'b0);
        cpu_rst = 1'b1;
        step();
        cpu_rst = 1'b0;
        chk("rst_seq_idle", in_ready, 1'b1);
        chk("rst_seq_pc_next", pc_next, 32'h0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
        step();
        mem_resp_valid = 1'b0;
        chk("rst_seq_late_rf", rf_wen, 1'b0);
        chk("rst_seq_late_pc", pc_wen, 1'b0);
        chk("rst_seq_late_idle", in_ready, 1'b1);
        $display("[TB] txn reset-in-RESP rf_wen=%0b pc_wen=%0b in_ready=%0b", rf_wen, pc_wen, in_ready);

        // Recovery after reset: a plain ALU op still works.
        alu = vecs[0];
        alu.rd = 5'd12; alu.wdata = 32'h0001_2345; alu.e_rfwdata = 32'h0001_2345; alu.npc = 32'h8000_0044;
        do_txn(13, alu);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
